// File: rtl/sw_seq_feeder.sv
// Host-side driver for the Smith-Waterman core: buffers one reference/query pair,
// streams it to the core, then captures the core's result or flags a watchdog timeout.
module sw_seq_feeder #(
    parameter int unsigned REF_LEN         = 64,
    parameter int unsigned QUERY_LEN       = 32,
    parameter int unsigned WIDTH_SCORE     = 8,
    parameter int unsigned WIDTH_POS_REF   = 7,
    parameter int unsigned WIDTH_POS_QUERY = 6,
    parameter int unsigned TIMEOUT         = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [WIDTH_POS_REF-1:0]   wr_addr,
    input  logic [1:0]                 wr_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       sw_valid,
    output logic [1:0]                 sw_data_ref,
    output logic [1:0]                 sw_data_query,
    input  logic                       sw_finish,
    input  logic [WIDTH_SCORE-1:0]     sw_max,
    input  logic [WIDTH_POS_REF-1:0]   sw_pos_ref,
    input  logic [WIDTH_POS_QUERY-1:0] sw_pos_query,
    output logic                       done,
    output logic                       err,
    output logic [WIDTH_SCORE-1:0]     res_max,
    output logic [WIDTH_POS_REF-1:0]   res_pos_ref,
    output logic [WIDTH_POS_QUERY-1:0] res_pos_query
);

    localparam int unsigned RA_W   = (REF_LEN > 1) ? $clog2(REF_LEN) : 1;
    localparam int unsigned QA_W   = (QUERY_LEN > 1) ? $clog2(QUERY_LEN) : 1;
    localparam int unsigned IDX_W  = $clog2(REF_LEN + 1);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT,
        ST_DONE
    } state_t;

    logic [1:0] ref_mem   [REF_LEN];
    logic [1:0] query_mem [QUERY_LEN];

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [WDOG_W-1:0]          wdog_q, wdog_d;
    logic [1:0]                 pre_ref_q, pre_ref_d;
    logic [1:0]                 pre_query_q, pre_query_d;
    logic                       busy_q, busy_d;
    logic                       valid_q, valid_d;
    logic [1:0]                 dref_q, dref_d;
    logic [1:0]                 dquery_q, dquery_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic [WIDTH_SCORE-1:0]     rmax_q, rmax_d;
    logic [WIDTH_POS_REF-1:0]   rpref_q, rpref_d;
    logic [WIDTH_POS_QUERY-1:0] rpq_q, rpq_d;

    logic                       wr_ok_c;
    logic [IDX_W-1:0]           idx_nxt_c;

    assign wr_ok_c   = (state_q == ST_IDLE) && wr_en;
    assign idx_nxt_c = idx_q + IDX_W'(1);

    // Sequence buffers; out-of-range addresses are dropped, contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok_c && !wr_sel && (32'(wr_addr) < REF_LEN)) begin
            ref_mem[wr_addr[RA_W-1:0]] <= wr_data;
        end
        if (wr_ok_c && wr_sel && (32'(wr_addr) < QUERY_LEN)) begin
            query_mem[wr_addr[QA_W-1:0]] <= wr_data;
        end
    end

    // Bases are prefetched one cycle ahead, so a write coinciding with start
    // misses element 0 (already fetched) but reaches every later element.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wdog_d      = wdog_q;
        pre_ref_d   = pre_ref_q;
        pre_query_d = pre_query_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        dref_d      = dref_q;
        dquery_d    = dquery_q;
        done_d      = 1'b0;
        err_d       = err_q;
        rmax_d      = rmax_q;
        rpref_d     = rpref_q;
        rpq_d       = rpq_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_STREAM;
                    idx_d       = '0;
                    wdog_d      = '0;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    pre_ref_d   = ref_mem[0];
                    pre_query_d = query_mem[0];
                end
            end
            ST_STREAM: begin
                valid_d     = 1'b1;
                dref_d      = pre_ref_q;
                dquery_d    = pre_query_q;
                pre_ref_d   = (32'(idx_nxt_c) < REF_LEN) ? ref_mem[idx_nxt_c[RA_W-1:0]] : 2'b00;
                pre_query_d = (32'(idx_nxt_c) < QUERY_LEN) ? query_mem[idx_nxt_c[QA_W-1:0]] : 2'b00;
                idx_d       = idx_nxt_c;
                if (idx_q == IDX_W'(REF_LEN - 1)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                valid_d  = 1'b0;
                dref_d   = 2'b00;
                dquery_d = 2'b00;
                if (sw_finish) begin
                    rmax_d  = sw_max;
                    rpref_d = sw_pos_ref;
                    rpq_d   = sw_pos_query;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            wdog_q      <= '0;
            pre_ref_q   <= 2'b00;
            pre_query_q <= 2'b00;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            dref_q      <= 2'b00;
            dquery_q    <= 2'b00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rmax_q      <= '0;
            rpref_q     <= '0;
            rpq_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wdog_q      <= wdog_d;
            pre_ref_q   <= pre_ref_d;
            pre_query_q <= pre_query_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            dref_q      <= dref_d;
            dquery_q    <= dquery_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rmax_q      <= rmax_d;
            rpref_q     <= rpref_d;
            rpq_q       <= rpq_d;
        end
    end

    assign busy          = busy_q;
    assign sw_valid      = valid_q;
    assign sw_data_ref   = dref_q;
    assign sw_data_query = dquery_q;
    assign done          = done_q;
    assign err           = err_q;
    assign res_max       = rmax_q;
    assign res_pos_ref   = rpref_q;
    assign res_pos_query = rpq_q;

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Bench for sw_seq_feeder: array-based model of the buffers and job timing,
// with a simple core model answering (or not) during the wait phase.
module tb_sw_seq_feeder;

    localparam int RL  = 64;
    localparam int QL  = 32;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, wr_sel, start;
    logic [6:0] wr_addr;
    logic [1:0] wr_data;
    logic       busy, sw_valid;
    logic [1:0] sw_data_ref, sw_data_query;
    logic       sw_finish;
    logic [7:0] sw_max;
    logic [6:0] sw_pos_ref;
    logic [5:0] sw_pos_query;
    logic       done, err;
    logic [7:0] res_max;
    logic [6:0] res_pos_ref;
    logic [5:0] res_pos_query;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] ref_m [RL];
    logic [1:0] qry_m [QL];
    logic [7:0] exp_max;
    logic [6:0] exp_pref;
    logic [5:0] exp_pq;
    logic       exp_err;

    sw_seq_feeder #(
        .REF_LEN(RL), .QUERY_LEN(QL), .WIDTH_SCORE(8),
        .WIDTH_POS_REF(7), .WIDTH_POS_QUERY(6), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .busy(busy),
        .sw_valid(sw_valid), .sw_data_ref(sw_data_ref), .sw_data_query(sw_data_query),
        .sw_finish(sw_finish), .sw_max(sw_max), .sw_pos_ref(sw_pos_ref),
        .sw_pos_query(sw_pos_query), .done(done), .err(err), .res_max(res_max),
        .res_pos_ref(res_pos_ref), .res_pos_query(res_pos_query)
    );

    always #5 clk = ~clk;

    task automatic write_base(input bit sel, input int addr, input logic [1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 7'(addr);
        wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (!sel && addr < RL) ref_m[addr] = data;
        if (sel && addr < QL)  qry_m[addr] = data;
    endtask

    // One job: optional write alongside start, optional busy-time junk, core answers at WAIT cycle fin_j.
    task automatic run_job(input string nm, input bit inject, input bit fin_en, input int fin_j,
                           input bit ws_en, input bit ws_sel, input int ws_addr, input logic [1:0] ws_data,
                           input logic [7:0] mx, input logic [6:0] pr, input logic [5:0] pq);
        logic [1:0] sref [RL];
        logic [1:0] sqry [QL];
        logic [1:0] eq;
        int got, exp_j;
        sref = ref_m;
        sqry = qry_m;
        if (ws_en) begin
            if (!ws_sel && ws_addr < RL) begin
                ref_m[ws_addr] = ws_data;
                if (ws_addr > 0) sref[ws_addr] = ws_data;
            end
            if (ws_sel && ws_addr < QL) begin
                qry_m[ws_addr] = ws_data;
                if (ws_addr > 0) sqry[ws_addr] = ws_data;
            end
        end
        start   = 1'b1;
        wr_en   = ws_en;
        wr_sel  = ws_sel;
        wr_addr = 7'(ws_addr);
        wr_data = ws_data;
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        vectors++;
        if ({busy, sw_valid, err, done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL %s launch: busy/valid/err/done=%b required 1000", nm, {busy, sw_valid, err, done});
        end
        for (int i = 0; i < RL; i++) begin
            if (inject && i < RL - 1) begin
                start     = 1'($urandom);
                wr_en     = 1'($urandom);
                wr_sel    = 1'($urandom);
                wr_addr   = 7'($urandom_range(0, 127));
                wr_data   = 2'($urandom);
                sw_finish = 1'($urandom);
            end else begin
                start = 1'b0; wr_en = 1'b0; sw_finish = 1'b0;
            end
            @(posedge clk); #1;
            eq = (i < QL) ? sqry[i] : 2'b00;
            vectors++;
            if ({busy, sw_valid, done, sw_data_ref, sw_data_query} !== {3'b110, sref[i], eq}) begin
                miscompares++;
                $display("FAIL %s stream[%0d]: busy/valid/done/ref/qry=%b required %b", nm, i,
                         {busy, sw_valid, done, sw_data_ref, sw_data_query}, {3'b110, sref[i], eq});
            end
        end
        start = 1'b0; wr_en = 1'b0;
        got = 0;
        for (int j = 1; j <= TMO + 8; j++) begin
            sw_finish = fin_en && (j == fin_j);
            sw_max       = sw_finish ? mx : 8'($urandom);
            sw_pos_ref   = sw_finish ? pr : 7'($urandom);
            sw_pos_query = sw_finish ? pq : 6'($urandom);
            @(posedge clk); #1;
            vectors++;
            if ({busy, sw_valid, sw_data_ref, sw_data_query} !== 6'b100000) begin
                miscompares++;
                $display("FAIL %s wait[%0d]: busy/valid/ref/qry=%b required 100000", nm, j,
                         {busy, sw_valid, sw_data_ref, sw_data_query});
            end
            if (done === 1'b1) begin
                got = j;
                break;
            end
        end
        sw_finish = 1'b0;
        exp_j = (fin_en && fin_j <= TMO) ? fin_j : TMO;
        if (fin_en && fin_j <= TMO) begin
            exp_max = mx; exp_pref = pr; exp_pq = pq; exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        vectors++;
        if (got != exp_j) begin
            miscompares++;
            $display("FAIL %s done_cycle: got wait cycle %0d required %0d (0 = never)", nm, got, exp_j);
        end
        vectors++;
        if ({err, res_max, res_pos_ref, res_pos_query} !== {exp_err, exp_max, exp_pref, exp_pq}) begin
            miscompares++;
            $display("FAIL %s result: err=%b max=%0d pref=%0d pq=%0d required err=%b max=%0d pref=%0d pq=%0d",
                     nm, err, res_max, res_pos_ref, res_pos_query, exp_err, exp_max, exp_pref, exp_pq);
        end
        @(posedge clk); #1;
        vectors++;
        if ({busy, done, err, res_max} !== {2'b00, exp_err, exp_max}) begin
            miscompares++;
            $display("FAIL %s after_done: busy/done=%b%b err=%b max=%0d required 00 %b %0d",
                     nm, busy, done, err, res_max, exp_err, exp_max);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        vectors++;
        if ({busy, sw_valid, done, err, sw_data_ref, sw_data_query, res_max, res_pos_ref, res_pos_query} !== '0) begin
            miscompares++;
            $display("FAIL %s: busy=%b valid=%b done=%b err=%b ref=%b qry=%b max=%0d pref=%0d pq=%0d required all 0",
                     nm, busy, sw_valid, done, err, sw_data_ref, sw_data_query, res_max, res_pos_ref, res_pos_query);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        sw_finish = 1'b0; sw_max = '0; sw_pos_ref = '0; sw_pos_query = '0;
        exp_max = '0; exp_pref = '0; exp_pq = '0; exp_err = 1'b0;
        #12;
        check_reset_outputs("reset_values");
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        sw_finish = 1'b1;
        @(posedge clk); #1;
        sw_finish = 1'b0;
        check_reset_outputs("idle_ignores_finish");
    endtask

    task automatic test_load_pattern();
        for (int i = 0; i < RL; i++) write_base(1'b0, i, 2'(i % 4));
        for (int i = 0; i < QL; i++) write_base(1'b1, i, 2'((i + 1) % 4));
        run_job("pattern_finish", 1'b0, 1'b1, 5, 1'b0, 1'b0, 0, 2'b00, 8'd57, 7'd40, 6'd20);
    endtask

    task automatic test_timeout();
        run_job("timeout", 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 2'b00, 8'd0, 7'd0, 6'd0);
    endtask

    task automatic test_busy_ignore();
        run_job("busy_junk", 1'b1, 1'b1, 3, 1'b0, 1'b0, 0, 2'b00, 8'($urandom), 7'($urandom), 6'($urandom));
        run_job("after_junk", 1'b0, 1'b1, 7, 1'b0, 1'b0, 0, 2'b00, 8'($urandom), 7'($urandom), 6'($urandom));
    endtask

    task automatic test_write_with_start();
        run_job("wstart_ref0", 1'b0, 1'b1, 2, 1'b1, 1'b0, 0, ~ref_m[0], 8'd1, 7'd2, 6'd3);
        run_job("wstart_qry5", 1'b0, 1'b1, 2, 1'b1, 1'b1, 5, ~qry_m[5], 8'd4, 7'd5, 6'd6);
        run_job("wstart_check", 1'b0, 1'b1, 1, 1'b0, 1'b0, 0, 2'b00, 8'd7, 7'd8, 6'd9);
    endtask

    task automatic test_drop_writes();
        write_base(1'b1, 40, ~qry_m[8]);
        write_base(1'b0, 100, ~ref_m[36]);
        write_base(1'b1, 32, ~qry_m[0]);
        run_job("oob_writes", 1'b0, 1'b1, 4, 1'b0, 1'b0, 0, 2'b00, 8'd99, 7'd63, 6'd31);
    endtask

    task automatic test_coincide();
        run_job("finish_at_timeout", 1'b0, 1'b1, TMO, 1'b0, 1'b0, 0, 2'b00, 8'd200, 7'd100, 6'd50);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b0;
        #1;
        exp_max = '0; exp_pref = '0; exp_pq = '0; exp_err = 1'b0;
        check_reset_outputs("mid_stream_reset");
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        check_reset_outputs("post_reset_idle");
        run_job("after_reset", 1'b0, 1'b1, 6, 1'b0, 1'b0, 0, 2'b00, 8'd11, 7'd22, 6'd33);
    endtask

    task automatic test_random_jobs();
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 20; k++) write_base(1'($urandom), $urandom_range(0, 70), 2'($urandom));
            run_job($sformatf("random%0d", n), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                    $urandom_range(1, TMO + 3), 1'($urandom), 1'($urandom), $urandom_range(0, 40),
                    2'($urandom), 8'($urandom), 7'($urandom), 6'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_load_pattern();
        test_timeout();
        test_busy_ignore();
        test_write_with_start();
        test_drop_writes();
        test_coincide();
        test_reset_mid();
        test_random_jobs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
